// File: rtl/channel_reduce_n.sv
// channel_reduce_n: pulls `count` words from an input channel, folds them with sum/max/min/xor
// and offers the result on an output channel. Define CHANNEL_REDUCE_N_SAT_EN for saturating sum + `overflow`.
module channel_reduce_n #(
    parameter int WIDTH      = 32,
    parameter int COUNT_W    = 8,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [COUNT_W-1:0] count,
    input  logic [WIDTH-1:0]   in_out_data,
    input  logic               in_read_ready,
    input  logic               in_write_ready,
    output logic               in_read_valid,
    output logic [WIDTH-1:0]   in_in_data,
    output logic               in_write_valid,
    output logic               in_rst,
    input  logic               out_write_ready,
    input  logic               out_read_ready,
    input  logic [WIDTH-1:0]   out_out_data,
    output logic [WIDTH-1:0]   out_in_data,
    output logic               out_write_valid,
    output logic               out_read_valid,
    output logic               out_rst,
    output logic               busy,
`ifdef CHANNEL_REDUCE_N_SAT_EN
    output logic               overflow,
`endif
    output logic               valid
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc, fold;
    logic [WIDTH:0]     sum;
    logic [COUNT_W-1:0] idx, count_q;
    logic [1:0]         mode_q;
    logic               valid_q;
    logic               last;
    logic               unused_ok;
`ifdef CHANNEL_REDUCE_N_SAT_EN
    logic               sat_hit;
`endif

    assign unused_ok = ^{in_write_ready, out_read_ready, out_out_data};
    assign last      = ({1'b0, idx} + 1'b1) == {1'b0, count_q};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        case (state)
            IDLE:    state_next = (count == '0) ? WRITE : READ;
            READ:    if (in_read_ready && last) state_next = WRITE;
            WRITE:   if (out_write_ready) state_next = CONTINUOUS ? IDLE : DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // One fold step of the latched operator; sum carries an extra bit to detect wrap.
    always_comb begin
        sum  = {1'b0, acc} + {1'b0, in_out_data};
        fold = sum[WIDTH-1:0];
`ifdef CHANNEL_REDUCE_N_SAT_EN
        sat_hit = 1'b0;
`endif
        case (mode_q)
            2'd0: begin
`ifdef CHANNEL_REDUCE_N_SAT_EN
                if (sum[WIDTH]) begin
                    fold    = '1;
                    sat_hit = 1'b1;
                end
`endif
            end
            2'd1:    fold = (in_out_data > acc) ? in_out_data : acc;
            2'd2:    fold = (in_out_data < acc) ? in_out_data : acc;
            default: fold = acc ^ in_out_data;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            count_q <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
`ifdef CHANNEL_REDUCE_N_SAT_EN
            overflow <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            valid_q <= (state == WRITE) && out_write_ready;
            case (state)
                IDLE: begin
                    mode_q  <= mode;
                    count_q <= count;
                    acc     <= (mode == 2'd2) ? '1 : '0;
                    idx     <= '0;
`ifdef CHANNEL_REDUCE_N_SAT_EN
                    overflow <= 1'b0;
`endif
                end
                READ: begin
                    if (in_read_ready) begin
                        acc <= fold;
                        idx <= idx + 1'b1;
`ifdef CHANNEL_REDUCE_N_SAT_EN
                        if (sat_hit) overflow <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // All handshake outputs decode registered state only; ready inputs never reach an output.
    assign in_read_valid   = (state == READ);
    assign out_write_valid = (state == WRITE);
    assign busy            = (state == READ) || (state == WRITE);
    assign out_in_data     = acc;
    assign valid           = CONTINUOUS ? valid_q : (state == DONE);

    assign in_in_data      = '0;
    assign in_write_valid  = 1'b0;
    assign in_rst          = 1'b0;
    assign out_read_valid  = 1'b0;
    assign out_rst         = 1'b0;

endmodule

// File: tb/tb_channel_reduce_n.sv
// Self-checking bench for channel_reduce_n: directed table, randomized runs against a
// behavioural model, reset abort, and the halting (CONTINUOUS=0) variant.
`timescale 1ns/1ps
module tb_channel_reduce_n;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   in_out_data;
    logic               in_read_ready, out_write_ready;
    logic               in_write_ready = 1'b0, out_read_ready = 1'b0;
    logic [WIDTH-1:0]   out_out_data = 32'hDEAD_BEEF;

    logic [1:0]       in_read_valid, in_write_valid, in_rst;
    logic [1:0]       out_write_valid, out_read_valid, out_rst, busy, valid;
    logic [WIDTH-1:0] in_in_data [2];
    logic [WIDTH-1:0] out_in_data [2];
`ifdef CHANNEL_REDUCE_N_SAT_EN
    logic [1:0]       overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit sel = 1'b0;
    logic [WIDTH-1:0] feed [256];

    logic rv, wv, vl;
    logic [WIDTH-1:0] od;
    always_comb begin
        rv = in_read_valid[sel];
        wv = out_write_valid[sel];
        vl = valid[sel];
        od = out_in_data[sel];
    end

    always #5 clk = ~clk;

    channel_reduce_n #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .CONTINUOUS(1'b1)) u_cont (
        .clk(clk), .rst(rst), .mode(mode), .count(count),
        .in_out_data(in_out_data), .in_read_ready(in_read_ready), .in_write_ready(in_write_ready),
        .in_read_valid(in_read_valid[0]), .in_in_data(in_in_data[0]),
        .in_write_valid(in_write_valid[0]), .in_rst(in_rst[0]),
        .out_write_ready(out_write_ready), .out_read_ready(out_read_ready), .out_out_data(out_out_data),
        .out_in_data(out_in_data[0]), .out_write_valid(out_write_valid[0]),
        .out_read_valid(out_read_valid[0]), .out_rst(out_rst[0]), .busy(busy[0]),
`ifdef CHANNEL_REDUCE_N_SAT_EN
        .overflow(overflow[0]),
`endif
        .valid(valid[0])
    );

    channel_reduce_n #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .CONTINUOUS(1'b0)) u_halt (
        .clk(clk), .rst(rst), .mode(mode), .count(count),
        .in_out_data(in_out_data), .in_read_ready(in_read_ready), .in_write_ready(in_write_ready),
        .in_read_valid(in_read_valid[1]), .in_in_data(in_in_data[1]),
        .in_write_valid(in_write_valid[1]), .in_rst(in_rst[1]),
        .out_write_ready(out_write_ready), .out_read_ready(out_read_ready), .out_out_data(out_out_data),
        .out_in_data(out_in_data[1]), .out_write_valid(out_write_valid[1]),
        .out_read_valid(out_read_valid[1]), .out_rst(out_rst[1]), .busy(busy[1]),
`ifdef CHANNEL_REDUCE_N_SAT_EN
        .overflow(overflow[1]),
`endif
        .valid(valid[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: fold feed[0..cnt-1] straight from the operator definitions.
    function automatic logic [WIDTH:0] model(input logic [1:0] m, input int cnt);
        longint unsigned total = 0;
        logic [WIDTH-1:0] r;
        bit ovf = 1'b0;
        case (m)
            2'd0: begin
                for (int i = 0; i < cnt; i++) total += longint'(feed[i]);
`ifdef CHANNEL_REDUCE_N_SAT_EN
                if (total > 64'h0000_0000_FFFF_FFFF) begin r = '1; ovf = 1'b1; end
                else r = total[WIDTH-1:0];
`else
                r = total[WIDTH-1:0];
`endif
            end
            2'd1: begin r = '0; for (int i = 0; i < cnt; i++) if (feed[i] > r) r = feed[i]; end
            2'd2: begin r = '1; for (int i = 0; i < cnt; i++) if (feed[i] < r) r = feed[i]; end
            default: begin r = '0; for (int i = 0; i < cnt; i++) r = r ^ feed[i]; end
        endcase
        return {ovf, r};
    endfunction

    // rd_mode: 0 ready always, 1 alternate 1/0 while reading, 2 random stalls.
    // wr_hold: cycles out_write_ready is held low once a result is offered (<0 = random).
    task automatic run(input logic [1:0] m, input int cnt, input int rd_mode, input int wr_hold,
                       input logic [WIDTH-1:0] exp, input bit exp_ovf, input string tag);
        int reads = 0, cyc = 0, held = 0, extra_rd = 0, early_v = 0;
        bit done = 1'b0, expect_wv = 1'b0, have_prev = 1'b0, tog = 1'b1, xr, xw, ovf_got = 1'b0;
        logic [WIDTH-1:0] prev = '0, got = '0;
        mode  = m;
        count = cnt[COUNT_W-1:0];
        while (!done && cyc < 3000) begin
            case (rd_mode)
                0:       in_read_ready = 1'b1;
                1:       in_read_ready = tog;
                default: in_read_ready = ($urandom_range(99) >= 30);
            endcase
            in_out_data = feed[(reads > 255) ? 255 : reads];
            if (wr_hold < 0) out_write_ready = 1'($urandom_range(1));
            else             out_write_ready = (held >= wr_hold);
            xr = rv && in_read_ready;
            xw = wv && out_write_ready;
            if (rv && reads >= cnt) extra_rd++;
            if (expect_wv) begin
                check({tag, "/latency"}, wv, 1'b1);
                expect_wv = 1'b0;
            end
            if (wv && have_prev) check({tag, "/hold"}, od, prev);
            if (wv) begin prev = od; have_prev = 1'b1; end
            if (wv && !xw) held++;
            if (rv) tog = !tog;
            if (xw) begin
                got = od;
`ifdef CHANNEL_REDUCE_N_SAT_EN
                ovf_got = overflow[sel];
`endif
            end
            @(posedge clk); #1;
            if (cyc == 0) begin
                mode  = 2'($urandom_range(3));
                count = COUNT_W'($urandom_range(255));
            end
            if (xr) begin
                reads++;
                if (reads == cnt) expect_wv = 1'b1;
            end
            if (xw) begin
                done = 1'b1;
                check({tag, "/valid"}, vl, 1'b1);
            end else if (vl) begin
                early_v++;
            end
            cyc++;
        end
        if (!done) check({tag, "/timeout"}, 1'b0, 1'b1);
        check({tag, "/result"}, got, exp);
        check({tag, "/reads"}, reads, cnt);
        check({tag, "/extra_read_valid"}, extra_rd, 0);
        check({tag, "/stray_valid"}, early_v, 0);
`ifdef CHANNEL_REDUCE_N_SAT_EN
        check({tag, "/overflow"}, ovf_got, exp_ovf);
`else
        if (ovf_got != exp_ovf) check({tag, "/overflow"}, ovf_got, exp_ovf);
`endif
    endtask

    typedef struct {
        logic [1:0]            m;
        int                    cnt;
        logic [3:0][WIDTH-1:0] d;
        int                    rd_mode;
        int                    wr_hold;
        logic [WIDTH-1:0]      exp;
        bit                    ovf;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int bad_v, bad_r, bad_w, bad_d;
        logic [WIDTH:0] ref_v;

        tbl[0] = '{2'd0, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 32'd10, 1'b0};
        tbl[1] = '{2'd1, 3, {32'd0, 32'd7, 32'hFFFF_FFF0, 32'd5}, 1, 0, 32'hFFFF_FFF0, 1'b0};
        tbl[2] = '{2'd2, 0, {32'd9, 32'd9, 32'd9, 32'd9}, 0, 0, 32'hFFFF_FFFF, 1'b0};
`ifdef CHANNEL_REDUCE_N_SAT_EN
        tbl[3] = '{2'd0, 2, {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, 0, 5, 32'hFFFF_FFFF, 1'b1};
`else
        tbl[3] = '{2'd0, 2, {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, 0, 5, 32'd1, 1'b0};
`endif
        tbl[4] = '{2'd3, 2, {32'd0, 32'd0, 32'h0F, 32'hA5}, 2, -1, 32'hAA, 1'b0};

        rst = 1'b1; mode = '0; count = '0; in_out_data = '0;
        in_read_ready = 1'b0; out_write_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset/outs%0d", k),
                  {in_read_valid[k], out_write_valid[k], busy[k], valid[k], out_in_data[k]}, '0);
            check($sformatf("reset/tied%0d", k),
                  {in_in_data[k], in_write_valid[k], in_rst[k], out_read_valid[k], out_rst[k]}, '0);
        end
        rst = 1'b0;

        sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) feed[i] = tbl[k].d[i];
            run(tbl[k].m, tbl[k].cnt, tbl[k].rd_mode, tbl[k].wr_hold, tbl[k].exp, tbl[k].ovf,
                $sformatf("vec%0d", k));
        end

        for (int t = 0; t < 40; t++) begin
            int cnt = (t == 39) ? 255 : $urandom_range(12);
            logic [1:0] m = 2'($urandom_range(3));
            for (int i = 0; i < 256; i++)
                feed[i] = ($urandom_range(3) == 0) ? 32'hFFFF_FF00 | $urandom_range(255) : $urandom;
            ref_v = model(m, cnt);
            run(m, cnt, 2, -1, ref_v[WIDTH-1:0], ref_v[WIDTH], $sformatf("rand%0d", t));
        end

        // Reset lands after two of four sum transfers; the partial result must vanish.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        mode = 2'd0; count = 8'd4; in_read_ready = 1'b1; out_write_ready = 1'b1;
        in_out_data = 32'd100;
        @(posedge clk); #1;
        in_out_data = 32'd100; @(posedge clk); #1;
        in_out_data = 32'd200; @(posedge clk); #1;
        rst = 1'b1; @(posedge clk); #1;
        check("abort/outs", {out_write_valid[0], in_read_valid[0], busy[0], valid[0], out_in_data[0]}, '0);
        rst = 1'b0;
        feed[0] = 32'd6; feed[1] = 32'd7;
        run(2'd0, 2, 0, 0, 32'd13, 1'b0, "after_abort");

        // Halting variant parks in DONE with valid held.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        sel = 1'b1;
        feed[0] = 32'hA5; feed[1] = 32'h0F;
        run(2'd3, 2, 0, 0, 32'hAA, 1'b0, "halt");
        bad_v = 0; bad_r = 0; bad_w = 0; bad_d = 0;
        in_read_ready = 1'b1; out_write_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (vl !== 1'b1) bad_v++;
            if (rv !== 1'b0) bad_r++;
            if (wv !== 1'b0) bad_w++;
            if (od !== 32'hAA) bad_d++;
        end
        check("halt/valid_held", bad_v, 0);
        check("halt/no_read", bad_r, 0);
        check("halt/no_write", bad_w, 0);
        check("halt/data_held", bad_d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
